regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data width of all write data.
REQ-002 The block SHALL have parameter REG_AW, default 5, giving the register address width (2**REG_AW registers).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: port clk, input, 1, rising-edge clock; port rst_n, input, 1, async active-low reset.
REQ-004 The block SHALL have port a_valid, input, 1: ALU result valid.
REQ-005 The block SHALL have port a_ready, output, 1: ALU result accepted this cycle.
REQ-006 The block SHALL have port a_rd, input, REG_AW: ALU destination register.
REQ-007 The block SHALL have port a_data, input, XLEN: ALU result.
REQ-008 The block SHALL have ports b_valid, b_ready, b_rd and b_data with the same widths and meanings for the load/multi-cycle unit.
REQ-009 The block SHALL have ports iss_valid, input, 1, and iss_rd, input, REG_AW: an instruction issued that will later write iss_rd.
REQ-010 The block SHALL have ports q_rs1 and q_rs2, input, REG_AW each: scoreboard query addresses.
REQ-011 The block SHALL have ports q_busy1 and q_busy2, output, 1 each: the queried register has a pending write.
REQ-012 The block SHALL have ports we3, output, 1; a3, output, REG_AW; and wd3, output, XLEN, forming the register-file write port.

Function
REQ-013 The block SHALL transfer a source when valid and ready are both high on a rising clk edge.
REQ-014 When exactly one source is valid, the block SHALL give that source ready=1 in the same cycle.
REQ-015 When both sources are valid, the block SHALL grant round-robin: the grant goes to the source not granted at the last contended cycle, and A wins the first contention after reset.
REQ-016 The block SHALL hold ready=0 for an invalid source; ready SHALL be a combinational function of the valids and the round-robin pointer only.
REQ-017 The block SHALL register each transfer onto we3/a3/wd3 the cycle after the handshake, giving a latency of 1 cycle with no output backpressure.
REQ-018 With no transfer, the block SHALL drive we3=0 in the following cycle and SHALL hold a3/wd3 at their last values.
REQ-019 A transfer with rd=0 SHALL be consumed (ready=1) but SHALL produce we3=0.
REQ-020 The scoreboard SHALL consist of pending bits [2**REG_AW-1:1]; iss_valid with iss_rd!=0 SHALL set pending[iss_rd] at the clock edge.
REQ-021 A granted transfer to rd!=0 SHALL clear pending[rd] at the handshake edge.
REQ-022 If a set and a clear of the same rd occur in one cycle, set SHALL win.
REQ-023 q_busy1 and q_busy2 SHALL be combinational: pending[q_rsN] && q_rsN!=0.
REQ-024 q_busy SHALL NOT bypass a same-cycle clear: busy stays 1 until the edge after the handshake.

Reset
REQ-025 While rst_n=0, the block SHALL hold we3=0, a3=0, wd3=0, all pending bits=0 and the round-robin pointer=A, asynchronously.
REQ-026 Reset SHALL deassert synchronously to clk; no transfer SHALL be accepted during the cycle in which rst_n=0.
REQ-027 A transfer already registered when reset asserts SHALL be dropped, with we3 forced low immediately.

Structure
REQ-028 XLEN, REG_AW and a source-select enum {SRC_A, SRC_B} SHALL reside in a shared package rf_pkg.
REQ-029 The arbiter SHALL be one sub-module, wb_rr_arb2, with inputs req[1:0], clk and rst_n, and output gnt[1:0] (one-hot or zero).
REQ-030 The scoreboard and output register SHALL reside in the top level.

Verification
REQ-031 Bench: reset, then a_valid with rd=5 and data=0x11 -> a_ready=1; next cycle we3=1, a3=5, wd3=0x11.
REQ-032 Bench: both sources valid for 4 cycles (A: rd=1, B: rd=2) -> grants A,B,A,B; we3 writes follow one cycle later in the same order.
REQ-033 Bench: b_valid with rd=0 and data=0xFF -> b_ready=1; next cycle we3=0.
REQ-034 Bench: iss rd=7, then q_rs1=7 -> q_busy1=1; after A writes rd=7, q_busy1=0 on the following cycle; with q_rs2=0, q_busy2 is always 0.
REQ-035 Bench: iss rd=3 in the same cycle as an A handshake to rd=3 -> pending[3] remains 1.
REQ-036 Bench: assert rst_n=0 mid-transfer -> we3=0 immediately, all q_busy=0, and the next contention is granted to A.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths and source identifiers for the register-file write-back path.
package rf_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_e;

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-requester round-robin arbiter; the grant is combinational from req and
// the priority pointer, which flips only on contended cycles.
module wb_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   import rf_pkg::*;

   src_e prio_r;

   // Grant selection: a lone requester always wins, the pointer breaks ties.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (prio_r == SRC_B) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   // Priority pointer: after a contended cycle the loser gets the next tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_r <= SRC_A;
      end else if (req == 2'b11) begin
         prio_r <= (prio_r == SRC_A) ? SRC_B : SRC_A;
      end else begin
         prio_r <= prio_r;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ALU and load/multi-cycle write-backs onto one register-file write
// port and tracks registers with in-flight writes for issue hazard checks.
module regfile_write_arbiter #(
   parameter int XLEN   = rf_pkg::XLEN,
   parameter int REG_AW = rf_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [REG_AW-1:0] a_rd,
   input  logic [XLEN-1:0]   a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [REG_AW-1:0] b_rd,
   input  logic [XLEN-1:0]   b_data,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic [REG_AW-1:0] q_rs1,
   input  logic [REG_AW-1:0] q_rs2,
   output logic              q_busy1,
   output logic              q_busy2,
   output logic              we3,
   output logic [REG_AW-1:0] a3,
   output logic [XLEN-1:0]   wd3
);
   import rf_pkg::*;

   localparam int NREG = 1 << REG_AW;
   localparam logic [REG_AW-1:0] RD_ZERO = {REG_AW{1'b0}};

   logic [1:0]        req_s;
   logic [1:0]        gnt_s;
   src_e              sel_src_s;
   logic              xfer_s;
   logic              wr_s;
   logic [REG_AW-1:0] sel_rd_s;
   logic [XLEN-1:0]   sel_data_s;
   logic [NREG-1:1]   pending_r;
   logic [NREG-1:1]   pending_nxt_s;
   logic [NREG-1:0]   pend_full_s;
   logic              we3_r;
   logic [REG_AW-1:0] a3_r;
   logic [XLEN-1:0]   wd3_r;

   assign req_s = {b_valid, a_valid};

   wb_rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_s),
      .gnt   (gnt_s)
   );

   assign a_ready = gnt_s[0];
   assign b_ready = gnt_s[1];

   // Route the granted source's destination and data.
   always_comb begin
      sel_src_s  = SRC_A;
      sel_rd_s   = a_rd;
      sel_data_s = a_data;
      if (gnt_s[1]) begin
         sel_src_s  = SRC_B;
         sel_rd_s   = b_rd;
         sel_data_s = b_data;
      end else begin
         sel_src_s  = SRC_A;
         sel_rd_s   = a_rd;
         sel_data_s = a_data;
      end
   end

   assign xfer_s = |gnt_s;
   assign wr_s   = xfer_s && (sel_rd_s != RD_ZERO);

   // Scoreboard next state: clear on write-back, then set on issue so a
   // same-cycle re-issue of the register keeps it pending.
   always_comb begin
      pending_nxt_s = pending_r;
      for (int i = 1; i < NREG; i++) begin
         if (wr_s && (sel_rd_s == REG_AW'(i))) begin
            pending_nxt_s[i] = 1'b0;
         end else begin
            pending_nxt_s[i] = pending_nxt_s[i];
         end
         if (iss_valid && (iss_rd == REG_AW'(i))) begin
            pending_nxt_s[i] = 1'b1;
         end else begin
            pending_nxt_s[i] = pending_nxt_s[i];
         end
      end
   end

   // Scoreboard storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r <= '0;
      end else begin
         pending_r <= pending_nxt_s;
      end
   end

   // Write-port register; address and data hold when nothing is written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we3_r <= 1'b0;
         a3_r  <= RD_ZERO;
         wd3_r <= {XLEN{1'b0}};
      end else if (wr_s) begin
         we3_r <= 1'b1;
         a3_r  <= sel_rd_s;
         wd3_r <= sel_data_s;
      end else begin
         we3_r <= 1'b0;
         a3_r  <= a3_r;
         wd3_r <= wd3_r;
      end
   end

   assign we3 = we3_r;
   assign a3  = a3_r;
   assign wd3 = wd3_r;

   // Bit 0 is padded so x0 never reads as busy.
   assign pend_full_s = {pending_r, 1'b0};
   assign q_busy1     = pend_full_s[q_rs1] && (q_rs1 != RD_ZERO);
   assign q_busy2     = pend_full_s[q_rs2] && (q_rs2 != RD_ZERO);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of arbitration and scoreboard.
module tb_regfile_write_arbiter;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              a_valid = 1'b0, b_valid = 1'b0, iss_valid = 1'b0;
   logic              a_ready, b_ready, q_busy1, q_busy2, we3;
   logic [REG_AW-1:0] a_rd = '0, b_rd = '0, iss_rd = '0, q_rs1 = '0, q_rs2 = '0, a3;
   logic [XLEN-1:0]   a_data = '0, b_data = '0, wd3;

   int checks = 0;
   int errors = 0;

   // Model state: who wins the next tie, pending registers, expected write port.
   bit              next_tie_b;
   bit              pend [32];
   bit              e_we;
   logic [4:0]      e_a3;
   logic [31:0]     e_wd3;
   bit              e_ar, e_br, e_b1, e_b2;

   regfile_write_arbiter #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .q_rs1(q_rs1), .q_rs2(q_rs2), .q_busy1(q_busy1), .q_busy2(q_busy2),
      .we3(we3), .a3(a3), .wd3(wd3)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      next_tie_b = 1'b0;
      foreach (pend[i]) pend[i] = 1'b0;
      e_we  = 1'b0;
      e_a3  = 5'd0;
      e_wd3 = 32'd0;
   endtask

   task automatic idle_inputs();
      a_valid = 1'b0; b_valid = 1'b0; iss_valid = 1'b0;
      a_rd = 5'd0; b_rd = 5'd0; iss_rd = 5'd0; q_rs1 = 5'd0; q_rs2 = 5'd0;
      a_data = 32'd0; b_data = 32'd0;
   endtask

   // Apply one cycle of inputs at the falling edge and predict combinational outputs.
   task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit bv, input logic [4:0] brd, input logic [31:0] bd,
                        input bit iv, input logic [4:0] ird,
                        input logic [4:0] r1, input logic [4:0] r2);
      @(negedge clk);
      a_valid = av; a_rd = ard; a_data = ad;
      b_valid = bv; b_rd = brd; b_data = bd;
      iss_valid = iv; iss_rd = ird; q_rs1 = r1; q_rs2 = r2;
      e_ar = av && !(bv && next_tie_b);
      e_br = bv && !(av && !next_tie_b);
      e_b1 = (r1 != 5'd0) && pend[r1];
      e_b2 = (r2 != 5'd0) && pend[r2];
      #1;
   endtask

   // Advance the model over one rising edge, then sample just after it.
   task automatic tick();
      logic [4:0]  wrd;
      logic [31:0] wdat;
      bit          moved;
      moved = e_ar || e_br;
      wrd   = e_ar ? a_rd : b_rd;
      wdat  = e_ar ? a_data : b_data;
      if (a_valid && b_valid) next_tie_b = e_ar;
      e_we = moved && (wrd != 5'd0);
      if (e_we) begin
         e_a3  = wrd;
         e_wd3 = wdat;
         pend[wrd] = 1'b0;
      end
      if (iss_valid && iss_rd != 5'd0) pend[iss_rd] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (we3 !== 1'b0 || a3 !== 5'd0 || wd3 !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs got we3=%0b a3=%0d wd3=%h want 0/0/0", we3, a3, wd3);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_a();
      drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_a_ready got a=%0b b=%0b want a=1 b=0", a_ready, b_ready);
      end
      tick();
      checks++;
      if (we3 !== 1'b1 || a3 !== 5'd5 || wd3 !== 32'h11) begin
         errors++;
         $display("FAIL single_a_write got we3=%0b a3=%0d wd3=%h want 1/5/11", we3, a3, wd3);
      end
   endtask

   task automatic test_contention();
      for (int k = 0; k < 4; k++) begin
         logic [31:0] da, db;
         bit want_a;
         da = $urandom; db = $urandom;
         want_a = (k % 2) == 0;
         drive(1'b1, 5'd1, da, 1'b1, 5'd2, db, 1'b0, 5'd0, 5'd0, 5'd0);
         checks++;
         if (a_ready !== want_a || b_ready !== !want_a) begin
            errors++;
            $display("FAIL contention_grant%0d got a=%0b b=%0b want a=%0b", k, a_ready, b_ready, want_a);
         end
         tick();
         checks++;
         if (we3 !== 1'b1 || a3 !== (want_a ? 5'd1 : 5'd2) || wd3 !== (want_a ? da : db)) begin
            errors++;
            $display("FAIL contention_write%0d got we3=%0b a3=%0d wd3=%h want a3=%0d", k, we3, a3, wd3,
                     want_a ? 1 : 2);
         end
      end
   endtask

   task automatic test_rd_zero();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 5'd0, 5'd0);
      checks++;
      if (b_ready !== 1'b1) begin
         errors++;
         $display("FAIL rd_zero_ready got %0b want 1", b_ready);
      end
      tick();
      checks++;
      if (we3 !== 1'b0) begin
         errors++;
         $display("FAIL rd_zero_we3 got %0b want 0", we3);
      end
   endtask

   task automatic test_scoreboard();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
      tick();
      drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
      checks++;
      if (q_busy1 !== 1'b1 || q_busy2 !== 1'b0) begin
         errors++;
         $display("FAIL sb_busy_no_bypass got b1=%0b b2=%0b want 1/0", q_busy1, q_busy2);
      end
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
      checks++;
      if (q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin
         errors++;
         $display("FAIL sb_busy_cleared got b1=%0b b2=%0b want 0/0", q_busy1, q_busy2);
      end
      tick();
   endtask

   task automatic test_set_wins();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0);
      tick();
      drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
      checks++;
      if (q_busy1 !== 1'b1) begin
         errors++;
         $display("FAIL set_wins got busy=%0b want 1", q_busy1);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      // Leave the pointer favouring B and register 9 pending.
      drive(1'b1, 5'd4, 32'h4, 1'b1, 5'd6, 32'h6, 1'b1, 5'd9, 5'd0, 5'd0);
      tick();
      drive(1'b1, 5'd10, 32'hA5A5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd10);
      tick();
      checks++;
      if (we3 !== 1'b1 || pend[9] !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_setup got we3=%0b want 1", we3);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (we3 !== 1'b0 || q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_async got we3=%0b b1=%0b b2=%0b want 0/0/0", we3, q_busy1, q_busy2);
      end
      idle_inputs();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13, 1'b0, 5'd0, 5'd0, 5'd0);
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_tie got a=%0b b=%0b want a=1 b=0", a_ready, b_ready);
      end
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         checks++;
         if (a_ready !== e_ar || b_ready !== e_br || q_busy1 !== e_b1 || q_busy2 !== e_b2) begin
            errors++;
            $display("FAIL rand_comb%0d got ar=%0b br=%0b b1=%0b b2=%0b want %0b %0b %0b %0b",
                     n, a_ready, b_ready, q_busy1, q_busy2, e_ar, e_br, e_b1, e_b2);
         end
         tick();
         checks++;
         if (we3 !== e_we || (e_we && (a3 !== e_a3 || wd3 !== e_wd3))) begin
            errors++;
            $display("FAIL rand_write%0d got we3=%0b a3=%0d wd3=%h want %0b %0d %h",
                     n, we3, a3, wd3, e_we, e_a3, e_wd3);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_a();
      test_contention();
      test_rd_zero();
      test_scoreboard();
      test_set_wins();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
